sync_frame_tx: RTL and testbench

- Serial frame transmitter; the transmit end of the "1101" sync-sequence link.
- On each accepted load it drives one bit per clock in this order: the 4-bit sync header 1-1-0-1, a PAYLOAD_W-bit payload MSB-first, one even-parity bit, then GAP_BITS idle bits.
- Its output feeds directly into the team's sequence detector, which flags the header on the 4th sync bit.

---
 rtl/sync_tx_pkg.sv | 24 ++
 rtl/flex_pts_sr.sv | 27 ++
 rtl/sync_frame_tx.sv | 140 ++++++++++++++
 tb/tb_sync_frame_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_tx_pkg.sv
// Shared types and constants for the sync-header serial frame transmitter.
package sync_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // Largest count any state needs; the bit counter is sized from this.
  function automatic int cnt_max(input int payload_w, input int gap_bits);
    int m;
    m = SYNC_LEN;
    if (payload_w > m) m = payload_w;
    if (gap_bits > m) m = gap_bits;
    return m;
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, MSB first, with synchronous load and shift enable.
module flex_pts_sr #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_par,
  output logic             o_ser
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_par;
    end else if (i_shift_en) begin
      r_data <= r_data << 1;
    end
  end

  assign o_ser = r_data[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 1101 sync header, MSB-first payload, even parity, idle gap.
module sync_frame_tx
  import sync_tx_pkg::*;
#(
  parameter int   PAYLOAD_W  = 8,
  parameter int   GAP_BITS   = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 serial_out,
  output logic                 frame_done,
  output state_t               o_dbg_state
);

  localparam int CNT_MAX = cnt_max(PAYLOAD_W, GAP_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_serial;
  logic             r_done;
  logic             r_parity;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_serial_nxt;
  logic             w_done_nxt;
  logic             w_parity_nxt;
  logic             w_sr_load;
  logic             w_sr_shift;
  logic             w_sr_msb;
  logic [1:0]       w_sync_idx;

  flex_pts_sr #(.WIDTH(PAYLOAD_W)) u_sr (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_sr_load),
    .i_shift_en (w_sr_shift),
    .i_par      (payload_in),
    .o_ser      (w_sr_msb)
  );

  // Bit 3 goes out at the accepting edge, so while in SYNC the counter picks bits 2..0.
  assign w_sync_idx = 2'(SYNC_LEN - 2) - r_cnt[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_serial <= IDLE_LEVEL;
      r_done   <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_serial <= w_serial_nxt;
      r_done   <= w_done_nxt;
      r_parity <= w_parity_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_serial_nxt = r_serial;
    w_done_nxt   = 1'b0;
    w_parity_nxt = r_parity;
    w_sr_load    = 1'b0;
    w_sr_shift   = 1'b0;
    case (r_state)
      IDLE: begin
        w_serial_nxt = IDLE_LEVEL;
        if (load) begin
          w_state_nxt  = SYNC;
          w_cnt_nxt    = '0;
          w_serial_nxt = SYNC_PATTERN[SYNC_LEN-1];
          w_sr_load    = 1'b1;
          w_parity_nxt = ^payload_in;
        end
      end
      SYNC: begin
        if (r_cnt == SYNC_LAST) begin
          w_state_nxt  = DATA;
          w_cnt_nxt    = '0;
          w_serial_nxt = w_sr_msb;
          w_sr_shift   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          w_serial_nxt = SYNC_PATTERN[w_sync_idx];
        end
      end
      DATA: begin
        if (r_cnt == DATA_LAST) begin
          w_state_nxt  = PARITY;
          w_cnt_nxt    = '0;
          w_serial_nxt = r_parity;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          w_serial_nxt = w_sr_msb;
          w_sr_shift   = 1'b1;
        end
      end
      PARITY: begin
        w_state_nxt  = GAP;
        w_cnt_nxt    = '0;
        w_serial_nxt = IDLE_LEVEL;
      end
      GAP: begin
        w_serial_nxt = IDLE_LEVEL;
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = '0;
        w_serial_nxt = IDLE_LEVEL;
      end
    endcase
  end

  assign ready       = (r_state == IDLE);
  assign busy        = ~ready;
  assign serial_out  = r_serial;
  assign frame_done  = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default 8-bit instance plus a 4-bit/1-gap instance.
module tb_sync_frame_tx;
  import sync_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       load;
  logic [7:0] payload;
  logic       ready, busy, serial_out, frame_done;
  state_t     dbg_state;

  logic       load4;
  logic [3:0] payload4;
  logic       ready4, busy4, serial4, done4;
  state_t     dbg_state4;

  sync_frame_tx #(.PAYLOAD_W(8), .GAP_BITS(2), .IDLE_LEVEL(1'b0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .payload_in  (payload),
    .ready       (ready),
    .busy        (busy),
    .serial_out  (serial_out),
    .frame_done  (frame_done),
    .o_dbg_state (dbg_state)
  );

  sync_frame_tx #(.PAYLOAD_W(4), .GAP_BITS(1), .IDLE_LEVEL(1'b0)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .load        (load4),
    .payload_in  (payload4),
    .ready       (ready4),
    .busy        (busy4),
    .serial_out  (serial4),
    .frame_done  (done4),
    .o_dbg_state (dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] hist  = 4'b0;  // last four serial bits seen by the 1101 detector model
  logic [3:0] hist4 = 4'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act.name(), exp.name());
    end
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, " serial"}, serial_out, 1'b0);
    check_bit({tag, " ready"},  ready,      1'b1);
    check_bit({tag, " busy"},   busy,       1'b0);
    check_bit({tag, " done"},   frame_done, 1'b0);
  endtask

  // Advance one clock and sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    hist  = {hist[2:0], serial_out};
    hist4 = {hist4[2:0], serial4};
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       load;
    logic [7:0] payload;
    logic       ser;
    logic       rdy;
    logic       bsy;
    logic       done;
    logic       det;
  } vec_t;

  vec_t vecs[$];

  task automatic add_idle(input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.load = 1'b0; v.payload = 8'h00; v.ser = 1'b0;
      v.rdy = 1'b1; v.bsy = 1'b0; v.done = 1'b0; v.det = 1'b0;
      vecs.push_back(v);
    end
  endtask

  // ser16/det16 bit 15 is cycle 1 after the accepting edge, bit 0 is cycle 16.
  task automatic add_frame(input logic [7:0] pay, input logic [15:0] ser16, input logic [15:0] det16);
    vec_t v;
    for (int k = 0; k < 16; k++) begin
      v.load    = (k == 0);
      v.payload = (k == 0) ? pay : ~pay;
      v.ser     = ser16[15-k];
      v.bsy     = (k != 15);
      v.rdy     = (k == 15);
      v.done    = (k == 15);
      v.det     = det16[15-k];
      vecs.push_back(v);
    end
  endtask

  // Load one frame on the 8-bit instance and check 16 cycles of serial/done/busy.
  task automatic run_frame16(input string tag, input logic [7:0] pay, input logic [15:0] ser16);
    load = 1'b1;
    payload = pay;
    for (int k = 1; k <= 16; k++) begin
      step();
      load = 1'b0;
      payload = ~pay;
      check_bit($sformatf("%s c%0d serial", tag, k), serial_out, ser16[16-k]);
      check_bit($sformatf("%s c%0d done", tag, k), frame_done, (k == 16));
      check_bit($sformatf("%s c%0d busy", tag, k), busy, (k != 16));
    end
  endtask

  logic [31:0] ser32;
  logic [10:0] ser11;
  logic [10:0] det11;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; payload = 8'h00; load4 = 1'b0; payload4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check_state("reset state", dbg_state, IDLE);
    check_bit("reset ready4", ready4, 1'b1);
    rst = 1'b0;

    // Idle with load low.
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
    end

    // Table: A5 frame, idle spacing, 07 frame with detector model.
    add_frame(8'hA5, 16'b1101_1010_0101_0000, 16'b0001_0010_0000_0000);
    add_idle(3);
    add_frame(8'h07, 16'b1101_0000_0111_1000, 16'b0001_0000_0000_0000);
    add_idle(2);
    for (int i = 0; i < vecs.size(); i++) begin
      load    = vecs[i].load;
      payload = vecs[i].payload;
      step();
      check_bit($sformatf("tbl%0d serial", i), serial_out, vecs[i].ser);
      check_bit($sformatf("tbl%0d ready", i),  ready,      vecs[i].rdy);
      check_bit($sformatf("tbl%0d busy", i),   busy,       vecs[i].bsy);
      check_bit($sformatf("tbl%0d done", i),   frame_done, vecs[i].done);
      check_bit($sformatf("tbl%0d det", i),    (hist == 4'b1101), vecs[i].det);
    end
    load = 1'b0;

    // Load held high: 3C frame, then FF accepted in the frame_done cycle.
    ser32 = 32'b1101_0011_1100_0000_1101_1111_1111_0000;
    for (int i = 0; i < 32; i++) begin
      load = 1'b1;
      if (i == 0) payload = 8'h3C;
      else if (i == 16) payload = 8'hFF;
      else payload = 8'($urandom_range(0, 255));
      step();
      check_bit($sformatf("hold c%0d serial", i + 1), serial_out, ser32[31-i]);
      check_bit($sformatf("hold c%0d done", i + 1), frame_done, (i == 15 || i == 31));
      check_bit($sformatf("hold c%0d busy", i + 1), busy, !(i == 15 || i == 31));
    end
    load = 1'b0;
    step();
    check_idle("hold after");

    // Reset in cycle 7 aborts the frame; a clean frame follows.
    load = 1'b1;
    payload = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      step();
      load = 1'b0;
      check_bit($sformatf("abort c%0d serial", k), serial_out, 7'b1101101 >> (7 - k) & 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check_idle("abort rst");
    check_state("abort state", dbg_state, IDLE);
    step();
    check_idle("abort rst edge");
    #2 rst = 1'b0;
    step();
    check_idle("post rst");
    run_frame16("postrst", 8'h07, 16'b1101_0000_0111_1000);

    // Narrow instance: payload D, detector aliasing at cycles 4 and 8.
    ser11 = 11'b1101_1101_100;
    det11 = 11'b0001_0001_000;
    hist4 = 4'b0;
    load4 = 1'b1;
    payload4 = 4'hD;
    for (int k = 1; k <= 11; k++) begin
      step();
      load4 = 1'b0;
      check_bit($sformatf("w4 c%0d serial", k), serial4, ser11[11-k]);
      check_bit($sformatf("w4 c%0d det", k), (hist4 == 4'b1101), det11[11-k]);
      check_bit($sformatf("w4 c%0d done", k), done4, (k == 11));
      check_bit($sformatf("w4 c%0d busy", k), busy4, (k != 11));
    end
    step();
    check_bit("w4 done clear", done4, 1'b0);
    check_state("w4 final state", dbg_state4, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
